present_key_schedule: RTL and testbench

//  Iterative PRESENT-80 key schedule: generates the 32 round keys that feed the key_addition stage.
//  It accepts one 80-bit user key through a valid/ready handshake, then streams round keys K1..K32 in order.

---
 rtl/present_key_schedule.sv | 169 ++++++++++++++++
 tb/tb_present_key_schedule.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/present_key_schedule.sv
// present_key_schedule
//
// Iterative PRESENT-80 key schedule. Accepts one 80-bit user key through a
// valid/ready handshake, then streams the 32 round keys K1..K32 in order,
// one per accepted beat. Each beat presents the whole 80-bit key register;
// the downstream key_addition stage uses rk[79:16].
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. The producer holds valid and its payload stable until the transfer
// happens, and the consumer may hold ready low for any number of cycles.
// This applies to req_* (this block is the consumer) and rk_* (this block is
// the producer).
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  user key present on req_key
//   req_ready  block can accept a key (high only in IDLE)
//   req_key    80-bit user key
//   abort      synchronous abort of the current stream (ignored in IDLE)
//   rk_valid   round key valid on rk / rk_idx / rk_last
//   rk_ready   consumer accepts the current round key
//   rk         current 80-bit key register, round key = rk[79:16]
//   rk_idx     index j of the presented key, rk is K(j+1)
//   rk_last    high together with rk_idx == 31 (final whitening key)
//   busy       high while streaming; a direct view of the FSM state
//              (busy=1 <=> EMIT)

module present_key_schedule #(
   parameter int KEY_W  = 80,
   parameter int ROUNDS = 31
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [KEY_W-1:0] req_key,
   input  logic             abort,
   output logic             rk_valid,
   input  logic             rk_ready,
   output logic [KEY_W-1:0] rk,
   output logic [4:0]       rk_idx,
   output logic             rk_last,
   output logic             busy
);

   localparam logic [4:0] LAST_IDX = 5'(ROUNDS);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [KEY_W-1:0] key_reg;
   logic [4:0]       idx;
   logic             req_fire;
   logic             rk_fire;

   // PRESENT 4-bit sbox
   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         default: y = 4'h2;
      endcase
      return y;
   endfunction

   // One key-register update: rotate left by 61, sbox the top nibble,
   // then mix the round counter into bits [19:15].
   function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                   input logic [4:0]       c);
      logic [KEY_W-1:0] t;
      t          = {k[18:0], k[79:19]};
      t[79:76]   = sbox(t[79:76]);
      t[19:15]   = t[19:15] ^ c;
      return t;
   endfunction

   assign req_fire = (state == IDLE) && req_valid;
   assign rk_fire  = (state == EMIT) && rk_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. abort wins over a simultaneous handshake on the
   // final beat; both lead back to IDLE anyway.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               state_next = EMIT;
            end
         end
         EMIT: begin
            if (abort) begin
               state_next = IDLE;
            end else if (rk_ready && (idx == LAST_IDX)) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      req_ready = 1'b0;
      rk_valid  = 1'b0;
      rk_last   = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
         end
         EMIT: begin
            rk_valid = 1'b1;
            busy     = 1'b1;
            rk_last  = (idx == LAST_IDX);
         end
         default: begin
            req_ready = 1'b0;
         end
      endcase
   end

   // Key register and index. A beat accepted together with abort is still
   // consumed, so the update proceeds; the stream is discarded on return
   // to IDLE regardless. On the final beat the register holds its value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_reg <= '0;
         idx     <= '0;
      end else if (req_fire) begin
         key_reg <= req_key;
         idx     <= '0;
      end else if (rk_fire && (idx != LAST_IDX)) begin
         key_reg <= key_update(key_reg, idx + 5'd1);
         idx     <= idx + 5'd1;
      end
   end

   assign rk     = key_reg;
   assign rk_idx = idx;

endmodule

// File: tb/tb_present_key_schedule.sv
// tb_present_key_schedule
//
// Directed bench for present_key_schedule: key streams for key=0 and
// key=all-ones against a bench-side key schedule model and published
// vectors, a full PRESENT-80 encryption of plaintext 0 under key 0 using
// the streamed keys, stall stability, abort, and mid-stream reset.

module tb_present_key_schedule;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [79:0] req_key;
   logic        abort;
   logic        rk_valid;
   logic        rk_ready;
   logic [79:0] rk;
   logic [4:0]  rk_idx;
   logic        rk_last;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [79:0] dut_keys [32];
   logic [3:0]  sbox_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                  4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   present_key_schedule dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_key   (req_key),
      .abort     (abort),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .rk        (rk),
      .rk_idx    (rk_idx),
      .rk_last   (rk_last),
      .busy      (busy)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference key update: rotate left 61, sbox top nibble, xor counter
   function automatic logic [79:0] ref_update(input logic [79:0] k, input int c);
      logic [79:0] t;
      logic [4:0]  cc;
      cc = 5'(c);
      t = (k << 61) | (k >> 19);
      t[79:76] = sbox_tab[t[79:76]];
      t[19:15] = t[19:15] ^ cc;
      return t;
   endfunction

   function automatic logic [63:0] sbox_layer(input logic [63:0] s);
      logic [63:0] o;
      for (int n = 0; n < 16; n++) begin
         o[n*4 +: 4] = sbox_tab[s[n*4 +: 4]];
      end
      return o;
   endfunction

   function automatic logic [63:0] p_layer(input logic [63:0] s);
      logic [63:0] o;
      o = '0;
      for (int b = 0; b < 63; b++) begin
         o[(b * 16) % 63] = s[b];
      end
      o[63] = s[63];
      return o;
   endfunction

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a key at the negedge; it is accepted on the next rising edge.
   task automatic accept(input logic [79:0] key);
      req_valid = 1'b1;
      req_key   = key;
      check("req_ready_before_accept", 80'(req_ready), 80'd1);
      @(negedge clk);
      req_valid = 1'b0;
      req_key   = $urandom();
   endtask

   // Walk the stream starting at idx 0. Every negedge the presented beat is
   // checked against the model; stalls re-check the same expectation.
   // Returns early (at a negedge, idx == stop_at visible) when stop_at < 32.
   task automatic consume(input logic [79:0] key, input bit rand_ready, input int stop_at);
      logic [79:0] ek;
      int          j;
      int          guard;
      bit          rdy;
      ek    = key;
      j     = 0;
      guard = 0;
      while (j < 32 && guard < 400) begin
         check("rk_valid", 80'(rk_valid), 80'd1);
         check("busy", 80'(busy), 80'd1);
         check("rk", rk, ek);
         check("rk_idx", 80'(rk_idx), 80'(j));
         check("rk_last", 80'(rk_last), 80'(j == 31));
         check("req_ready_in_emit", 80'(req_ready), 80'd0);
         if (j == stop_at) begin
            rk_ready = 1'b0;
            return;
         end
         rdy      = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         rk_ready = rdy;
         dut_keys[j] = rk;
         @(negedge clk);
         if (rdy) begin
            if (j < 31) begin
               ek = ref_update(ek, j + 1);
            end
            j++;
         end
         guard++;
      end
      rk_ready = 1'b0;
      check("stream_within_budget", 80'(guard < 400), 80'd1);
      check("rk_valid_after_last", 80'(rk_valid), 80'd0);
      check("req_ready_after_last", 80'(req_ready), 80'd1);
      check("busy_after_last", 80'(busy), 80'd0);
   endtask

   initial begin : stimulus
      logic [63:0] st;
      logic [79:0] key_b;

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_key   = '0;
      abort     = 1'b0;
      rk_ready  = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      check("reset_req_ready", 80'(req_ready), 80'd1);
      check("reset_rk_valid", 80'(rk_valid), 80'd0);
      check("reset_rk", rk, 80'd0);
      check("reset_rk_idx", 80'(rk_idx), 80'd0);
      check("reset_rk_last", 80'(rk_last), 80'd0);
      check("reset_busy", 80'(busy), 80'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Key 0, always ready, plus published first round keys
      accept(80'd0);
      consume(80'd0, 1'b0, 32);
      check("k1_top64", 80'(dut_keys[1][79:16]), 80'(64'hC000000000000000));
      check("k2_top64", 80'(dut_keys[2][79:16]), 80'(64'h5000180000000001));

      // Full encryption of plaintext 0 with the streamed keys
      st = '0;
      for (int r = 0; r < 31; r++) begin
         st = st ^ dut_keys[r][79:16];
         st = sbox_layer(st);
         st = p_layer(st);
      end
      st = st ^ dut_keys[31][79:16];
      check("ciphertext_key0", 80'(st), 80'(64'h5579C1387B228445));

      // Key 0 with random back-pressure
      @(negedge clk);
      accept(80'd0);
      consume(80'd0, 1'b1, 32);

      // All-ones key
      accept({80{1'b1}});
      consume({80{1'b1}}, 1'b1, 32);
      check("ones_first_beat", dut_keys[0], {80{1'b1}});

      // Abort at idx 10 together with a handshake; abort wins
      accept(80'h0123_4567_89AB_CDEF_1357);
      consume(80'h0123_4567_89AB_CDEF_1357, 1'b0, 10);
      abort    = 1'b1;
      rk_ready = 1'b1;
      @(negedge clk);
      abort    = 1'b0;
      rk_ready = 1'b0;
      check("abort_rk_valid", 80'(rk_valid), 80'd0);
      check("abort_req_ready", 80'(req_ready), 80'd1);
      check("abort_busy", 80'(busy), 80'd0);

      // abort held in IDLE is ignored; the new stream restarts at idx 0
      abort = 1'b1;
      accept(80'd0);
      abort = 1'b0;
      consume(80'd0, 1'b0, 32);

      // Asynchronous reset at idx 20 with a key waiting on req
      key_b = 80'hFEDC_BA98_7654_3210_ABCD;
      accept(80'h5555_AAAA_5555_AAAA_5555);
      consume(80'h5555_AAAA_5555_AAAA_5555, 1'b1, 20);
      rst_n     = 1'b0;
      req_valid = 1'b1;
      req_key   = key_b;
      #1;
      check("async_rst_rk_valid", 80'(rk_valid), 80'd0);
      check("async_rst_rk", rk, 80'd0);
      check("async_rst_rk_idx", 80'(rk_idx), 80'd0);
      check("async_rst_req_ready", 80'(req_ready), 80'd1);
      check("async_rst_busy", 80'(busy), 80'd0);
      repeat (2) @(negedge clk);
      check("held_rst_rk_valid", 80'(rk_valid), 80'd0);
      check("held_rst_rk", rk, 80'd0);
      rst_n = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      consume(key_b, 1'b0, 32);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit
   initial begin : watchdog
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule
